// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//
// Parameterised ripple-carry adder built from per-bit full-adder cells.
// Produces a zero-latency combinational sum/carry and a registered copy of
// the result together with a signed-overflow flag and a one-cycle valid.
// WIDTH=1 is the classic single-bit full adder.
//
// Parameters:
//   WIDTH   operand width in bits (>= 1)
//
// Ports:
//   clk     system clock; registered outputs update on the rising edge
//   rst_n   asynchronous active-low reset; clears the registered stage only
//   a, b    operands (unsigned or two's complement)
//   cin     carry into bit 0
//   en      capture enable for the registered stage
//   sum     combinational (a + b + cin) mod 2^WIDTH
//   cout    combinational carry out of the MSB
//   sum_q   registered sum
//   cout_q  registered carry out
//   ovf_q   registered signed overflow
//   vld_q   high the cycle after a capture (en=1)
// ----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             vld_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0] carry;
    logic           ovf;

    assign carry[0] = cin;

    // One full-adder cell per bit, chained through the carry vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic prop;

        assign prop         = a[i] ^ b[i];
        assign sum[i]       = prop ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & prop);
    end

    assign cout = carry[WIDTH];

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1 the carry into the sign bit is cin itself.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    // Registered stage.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= en;
            // NOTE: holding on en=0 inside a clocked block infers a
            // clock-enabled flop, not a latch.
            if (en) begin
                sum_q  <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
//
// Self-checking bench for full_adder. Two instances (WIDTH=8 and WIDTH=1)
// share clock and reset. Combinational outputs are checked directly right
// after the inputs change; registered results are checked by a scoreboard:
// stimulus pushes the expected capture, and a monitor pops and compares
// whenever vld_q is observed high on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_full_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk;
    logic       clk_on;
    logic       rst_n;

    logic [7:0] a8, b8, sum8, sum_q8;
    logic       cin8, en8, cout8, cout_q8, ovf_q8, vld_q8;

    logic [0:0] a1, b1, sum1, sum_q1;
    logic       cin1, en1, cout1, cout_q1, ovf_q1, vld_q1;

    int checks   = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q1[$];

    logic [1:0] sweep_exp [8];

    full_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .en    (en8),
        .sum   (sum8),
        .cout  (cout8),
        .sum_q (sum_q8),
        .cout_q(cout_q8),
        .ovf_q (ovf_q8),
        .vld_q (vld_q8)
    );

    full_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .en    (en1),
        .sum   (sum1),
        .cout  (cout1),
        .sum_q (sum_q1),
        .cout_q(cout_q1),
        .ovf_q (ovf_q1),
        .vld_q (vld_q1)
    );

    // Clock is held low until the no-clock sweep is done.
    initial clk = 1'b0;
    always #5 if (clk_on) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic e);
        a8   = a;
        b8   = b;
        cin8 = c;
        en8  = e;
    endtask

    task automatic expect_cap8(input logic [7:0] s, input logic c, input logic o);
        exp_t x;
        x.s = s;
        x.c = c;
        x.o = o;
        q8.push_back(x);
    endtask

    // Monitors: one pop per observed valid.
    always @(negedge clk) begin
        if (vld_q8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("sb8_vld_without_capture", 32'(vld_q8), 32'd0);
            end else begin
                exp_t x;
                x = q8.pop_front();
                check("sb8_sum_q",  32'(sum_q8),  32'(x.s));
                check("sb8_cout_q", 32'(cout_q8), 32'(x.c));
                check("sb8_ovf_q",  32'(ovf_q8),  32'(x.o));
            end
        end
    end

    always @(negedge clk) begin
        if (vld_q1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("sb1_vld_without_capture", 32'(vld_q1), 32'd0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                check("sb1_sum_q",  32'(sum_q1),  32'(x.s[0]));
                check("sb1_cout_q", 32'(cout_q1), 32'(x.c));
                check("sb1_ovf_q",  32'(ovf_q1),  32'(x.o));
            end
        end
    end

    // Watchdog: the stimulus is bounded, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // {cout,sum} for (a,b,cin) = 000..111
        sweep_exp[0] = 2'b00; sweep_exp[1] = 2'b01;
        sweep_exp[2] = 2'b01; sweep_exp[3] = 2'b10;
        sweep_exp[4] = 2'b01; sweep_exp[5] = 2'b10;
        sweep_exp[6] = 2'b10; sweep_exp[7] = 2'b11;

        clk_on = 1'b0;
        rst_n  = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b0);
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; en1 = 1'b0;

        // WIDTH=1 exhaustive sweep, combinational only, no clock edges,
        // and performed while in reset.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1[0] = v[2]; b1[0] = v[1]; cin1 = v[0];
            #1;
            check("w1_sweep_sum",  32'(sum1),  32'(sweep_exp[i][0]));
            check("w1_sweep_cout", 32'(cout1), 32'(sweep_exp[i][1]));
            #9;
        end

        // Reset state of the registered stage.
        check("rst_sum_q8",  32'(sum_q8),  32'd0);
        check("rst_cout_q8", 32'(cout_q8), 32'd0);
        check("rst_ovf_q8",  32'(ovf_q8),  32'd0);
        check("rst_vld_q8",  32'(vld_q8),  32'd0);
        check("rst_sum_q1",  32'(sum_q1),  32'd0);
        check("rst_vld_q1",  32'(vld_q1),  32'd0);

        clk_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around: 0xFF + 0x01
        @(negedge clk);
        drive8(8'hFF, 8'h01, 1'b0, 1'b1);
        expect_cap8(8'h00, 1'b1, 1'b0);
        #1;
        check("wrap_sum",  32'(sum8),  32'h00);
        check("wrap_cout", 32'(cout8), 32'd1);

        // Signed overflow: 0x7F + 0x00 + 1
        @(negedge clk);
        drive8(8'h7F, 8'h00, 1'b1, 1'b1);
        expect_cap8(8'h80, 1'b0, 1'b1);
        #1;
        check("ovf_pos_sum",  32'(sum8),  32'h80);
        check("ovf_pos_cout", 32'(cout8), 32'd0);

        // Signed overflow: 0x80 + 0x80
        @(negedge clk);
        drive8(8'h80, 8'h80, 1'b0, 1'b1);
        expect_cap8(8'h00, 1'b1, 1'b1);
        #1;
        check("ovf_neg_sum",  32'(sum8),  32'h00);
        check("ovf_neg_cout", 32'(cout8), 32'd1);

        // Enable hold: capture 0x12 + 0x34 + 1 = 0x47, then drop en.
        @(negedge clk);
        drive8(8'h12, 8'h34, 1'b1, 1'b1);
        expect_cap8(8'h47, 1'b0, 1'b0);
        #1;
        check("hold_cap_sum", 32'(sum8), 32'h47);

        @(negedge clk);
        drive8(8'h01, 8'h01, 1'b0, 1'b0);
        #1;
        check("hold_comb_sum", 32'(sum8),   32'h02);
        check("hold_sum_q",    32'(sum_q8), 32'h47);

        @(negedge clk);
        check("hold_sum_q_next", 32'(sum_q8), 32'h47);
        check("hold_vld_q_low",  32'(vld_q8), 32'd0);

        // Asynchronous reset between clock edges; a pending en=1 is discarded.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum_q",  32'(sum_q8),  32'd0);
        check("arst_cout_q", 32'(cout_q8), 32'd0);
        check("arst_ovf_q",  32'(ovf_q8),  32'd0);
        check("arst_vld_q",  32'(vld_q8),  32'd0);
        drive8(8'h10, 8'h20, 1'b0, 1'b1);
        #1;
        check("arst_comb_sum", 32'(sum8), 32'h30);

        @(negedge clk);
        check("arst_held_vld_q", 32'(vld_q8), 32'd0);
        check("arst_held_sum_q", 32'(sum_q8), 32'd0);
        drive8(8'h05, 8'h06, 1'b1, 1'b1);
        #1;
        check("arst_comb_sum2", 32'(sum8), 32'h0C);
        #1;
        rst_n = 1'b1;
        expect_cap8(8'h0C, 1'b0, 1'b0);

        @(negedge clk);
        drive8(8'h00, 8'h00, 1'b0, 1'b0);

        // Random: both widths, random enable, model is plain addition plus
        // sign-based overflow.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rc, re, r1a, r1b, r1c, r1e;
            logic [8:0] t8;
            logic [1:0] t1;
            exp_t       x;

            @(negedge clk);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            re  = ($urandom_range(0, 3) != 0);
            r1a = 1'($urandom);
            r1b = 1'($urandom);
            r1c = 1'($urandom);
            r1e = ($urandom_range(0, 3) != 0);

            drive8(ra, rb, rc, re);
            a1[0] = r1a; b1[0] = r1b; cin1 = r1c; en1 = r1e;

            t8 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            t1 = 2'(r1a) + 2'(r1b) + 2'(r1c);

            if (re) begin
                x.s = t8[7:0];
                x.c = t8[8];
                x.o = (ra[7] == rb[7]) && (t8[7] != ra[7]);
                q8.push_back(x);
            end
            if (r1e) begin
                x.s = {7'd0, t1[0]};
                x.c = t1[1];
                x.o = (r1a == r1b) && (t1[0] != r1a);
                q1.push_back(x);
            end

            #1;
            check("rand8_sum",  32'(sum8),  32'(t8[7:0]));
            check("rand8_cout", 32'(cout8), 32'(t8[8]));
            check("rand1_sum",  32'(sum1),  32'(t1[0]));
            check("rand1_cout", 32'(cout1), 32'(t1[1]));
        end

        @(negedge clk);
        en8 = 1'b0;
        en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
